branch_resolver: RTL

Resolves branches at the end of the execute stage against the fetch-time prediction carried down the pipeline. On a mispredict it raises a one-shot pipeline flush with the correct next PC. On a taken branch whose target the BTB does not already hold correctly, it queues a BTB write and drains the queue to the branch predictor's update port over a valid/ready handshake. It is the writer side of the predictor's `upEN` / `tag` / `br_a` update interface.

---
 rtl/branch_resolver_pkg.sv | 17 +
 rtl/branch_resolver_if.sv | 32 +++
 rtl/branch_update_fifo.sv | 50 +++++
 rtl/branch_resolver.sv | 111 +++++++++++
 4 files changed

// File: rtl/branch_resolver_pkg.sv
// Shared CPU types for branch resolution and BTB update traffic.
// Header-only: no latency, no flow control.
package cpu_types_pkg;

    localparam int BPQ_DEPTH = 2;

    typedef struct packed {
        logic [29:0] tag;
        logic [29:0] target;
    } bpupd_t;

    typedef enum logic {
        IDLE,
        FLUSH
    } brres_state_t;

endpackage

// File: rtl/branch_resolver_if.sv
// Resolution inputs and predictor update handshake; master is the update writer.
// Wires only: no latency. upd_valid/upd_ready is a plain valid-ready handshake.
interface branch_resolver_if;

    logic        res_valid;
    logic [29:0] res_pc;
    logic        res_taken;
    logic [29:0] res_target;
    logic [29:0] res_npc;
    logic        pred_hit;
    logic [29:0] pred_addr;

    logic        upd_valid;
    logic        upd_ready;
    logic [29:0] upd_tag;
    logic [29:0] upd_target;

    modport master (
        input  res_valid, res_pc, res_taken, res_target, res_npc,
        input  pred_hit, pred_addr,
        input  upd_ready,
        output upd_valid, upd_tag, upd_target
    );

    modport slave (
        output res_valid, res_pc, res_taken, res_target, res_npc,
        output pred_hit, pred_addr,
        output upd_ready,
        input  upd_valid, upd_tag, upd_target
    );

endinterface

// File: rtl/branch_update_fifo.sv
// In-order bpupd_t FIFO feeding the predictor update port.
// Latency: push visible at head the next cycle. Full push without pop is dropped (overflow pulse).
module branch_update_fifo
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = BPQ_DEPTH
) (
    input  logic   CLK,
    input  logic   RST,
    input  logic   push,
    input  bpupd_t push_dat,
    input  logic   pop,
    output bpupd_t head_dat,
    output logic   full,
    output logic   empty,
    output logic   overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    bpupd_t      mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_pop;
    logic        do_push;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign overflow = push & full & ~do_pop;
    assign head_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/branch_resolver.sv
// Execute-stage branch resolution: one-shot flush/redirect on mispredict, BTB update queue.
// Latency: flush/redirect_pc one cycle after acceptance; update head one cycle after enqueue.
// Backpressure: upd_ready stalls the queue head; overflow discards. BRANCH_RESOLVER_STATS_EN adds counters.
module branch_resolver
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = BPQ_DEPTH
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               stall,
    branch_resolver_if.master  bif,
    output logic               flush,
    output logic [31:0]        redirect_pc
`ifdef BRANCH_RESOLVER_STATS_EN
   ,output logic [31:0]        br_count,
    output logic [31:0]        mispred_count,
    output logic [15:0]        drop_count
`endif
);

    brres_state_t state;
    brres_state_t state_nxt;
    logic         accept;
    logic         taken_mis;
    logic         nt_mis;
    logic         mispred;
    logic         enqueue;
    logic [29:0]  redirect_word;
    bpupd_t       push_dat;
    bpupd_t       head_dat;
    logic         q_empty;
    logic         q_pop;
`ifdef BRANCH_RESOLVER_STATS_EN
    logic         q_overflow;
`endif

    assign accept    = bif.res_valid & ~stall & (state == IDLE);
    // A taken branch needs a BTB write unless the BTB already held the right target.
    assign taken_mis = bif.res_taken & (~bif.pred_hit | (bif.pred_addr != bif.res_target));
    // Hit-but-not-taken redirects only: the predictor cannot invalidate an entry.
    assign nt_mis    = ~bif.res_taken & bif.pred_hit;
    assign mispred   = accept & (taken_mis | nt_mis);
    assign enqueue   = accept & taken_mis;

    assign push_dat.tag    = bif.res_pc;
    assign push_dat.target = bif.res_target;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (mispred) state_nxt = FLUSH;
            FLUSH:   if (!stall)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        flush = (state == FLUSH);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)          redirect_word <= '0;
        else if (mispred) redirect_word <= bif.res_taken ? bif.res_target : bif.res_npc;
    end

    assign redirect_pc = {redirect_word, 2'b00};

    branch_update_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK      (CLK),
        .RST      (RST),
        .push     (enqueue),
        .push_dat (push_dat),
        .pop      (q_pop),
        .head_dat (head_dat),
        .full     (),
        .empty    (q_empty),
`ifdef BRANCH_RESOLVER_STATS_EN
        .overflow (q_overflow)
`else
        .overflow ()
`endif
    );

    assign bif.upd_valid  = ~q_empty;
    assign bif.upd_tag    = head_dat.tag;
    assign bif.upd_target = head_dat.target;
    assign q_pop          = bif.upd_valid & bif.upd_ready;

`ifdef BRANCH_RESOLVER_STATS_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            br_count      <= '0;
            mispred_count <= '0;
            drop_count    <= '0;
        end else begin
            if (accept && br_count != '1)       br_count      <= br_count + 32'd1;
            if (mispred && mispred_count != '1) mispred_count <= mispred_count + 32'd1;
            if (q_overflow && drop_count != '1) drop_count    <= drop_count + 16'd1;
        end
    end
`endif

endmodule
